// File: rtl/vector_checker_pkg.sv
// Shared types and helpers for the exhaustive-vector response checker.
package vector_checker_pkg;

    // Run phases of the checker.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // CCITT-style MISR feedback polynomial used unless overridden.
    localparam logic [15:0] DEFAULT_SIG_POLY = 16'h1021;

    // Upper bounds for the golden-table lookup helper.
    localparam int MAX_TBL_W = 1024;
    localparam int MAX_OUT_W = 16;

    // Returns entry idx of a packed golden table whose entries are out_w bits wide,
    // zero-extended to MAX_OUT_W bits.
    function automatic logic [MAX_OUT_W-1:0] expect_entry(
        input logic [MAX_TBL_W-1:0] tbl,
        input int unsigned          idx,
        input int unsigned          out_w
    );
        logic [MAX_TBL_W-1:0] shifted;
        logic [MAX_OUT_W-1:0] mask;
        shifted = tbl >> (idx * out_w);
        mask    = MAX_OUT_W'((33'd1 << out_w) - 33'd1);
        return shifted[MAX_OUT_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/response_misr.sv
// Multiple-input signature register compacting one response word per enabled cycle.
module response_misr
    import vector_checker_pkg::*;
#(
    parameter int               SIG_W    = 16,
    parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(DEFAULT_SIG_POLY),
    parameter int               OUT_W    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [OUT_W-1:0] din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_reg;
    logic [SIG_W-1:0] sig_next;

    // Shift left, fold the outgoing MSB back through the taps, inject the response.
    always_comb begin
        sig_next = {sig_reg[SIG_W-2:0], 1'b0}
                 ^ (sig_reg[SIG_W-1] ? SIG_POLY : '0)
                 ^ SIG_W'(din);
    end

    // Signature register; clear wins over a simultaneous update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_reg <= '0;
        end else if (clr) begin
            sig_reg <= '0;
        end else if (en) begin
            sig_reg <= sig_next;
        end
    end

    assign sig = sig_reg;

endmodule

// File: rtl/vector_response_checker.sv
// Consumes (vector, response) pairs of an exhaustive run, checks them against a golden
// table, counts failures, latches the first failing vector and builds a MISR signature.
module vector_response_checker
    import vector_checker_pkg::*;
#(
    parameter int                             IN_W     = 4,
    parameter int                             OUT_W    = 2,
    parameter logic [(2**IN_W)*OUT_W-1:0]     EXPECT   = '0,
    parameter int                             SIG_W    = 16,
    parameter logic [SIG_W-1:0]               SIG_POLY = SIG_W'(DEFAULT_SIG_POLY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vec_valid,
    input  logic [IN_W-1:0]  vec_in,
    input  logic [OUT_W-1:0] resp_in,
    output logic             vec_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [IN_W:0]    err_count,
    output logic             first_fail_valid,
    output logic [IN_W-1:0]  first_fail_vec,
    output logic [SIG_W-1:0] signature
);

    // Accepted-count value at which the next accept completes the run.
    localparam logic [IN_W:0] LAST_ACC = (IN_W+1)'(2**IN_W - 1);

    state_t            state_reg;
    state_t            state_next;
    logic [IN_W-1:0]   seq_cnt_reg;
    logic [IN_W:0]     acc_cnt_reg;
    logic [IN_W:0]     err_count_reg;
    logic              ff_valid_reg;
    logic [IN_W-1:0]   ff_vec_reg;

    logic              in_run;
    logic              accept;
    logic              start_run;
    logic              pair_fail;

    assign in_run    = (state_reg == RUN);
    assign accept    = in_run && vec_valid;
    // start only acts outside a run; during RUN it is ignored.
    assign start_run = start && !in_run;
    assign pair_fail = (vec_in != seq_cnt_reg)
                    || (expect_entry(MAX_TBL_W'(EXPECT), 32'(seq_cnt_reg), OUT_W)
                        != MAX_OUT_W'(resp_in));

    // Next-state logic: start opens a run, the final accept closes it.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (accept && (acc_cnt_reg == LAST_ACC)) state_next = DONE;
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Sequence/accept counters, error count and first-failure capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_cnt_reg   <= '0;
            acc_cnt_reg   <= '0;
            err_count_reg <= '0;
            ff_valid_reg  <= 1'b0;
            ff_vec_reg    <= '0;
        end else if (start_run) begin
            seq_cnt_reg   <= '0;
            acc_cnt_reg   <= '0;
            err_count_reg <= '0;
            ff_valid_reg  <= 1'b0;
            ff_vec_reg    <= '0;
        end else if (accept) begin
            seq_cnt_reg <= seq_cnt_reg + IN_W'(1);
            acc_cnt_reg <= acc_cnt_reg + (IN_W+1)'(1);
            if (pair_fail) begin
                err_count_reg <= err_count_reg + (IN_W+1)'(1);
                if (!ff_valid_reg) begin
                    ff_valid_reg <= 1'b1;
                    ff_vec_reg   <= vec_in;
                end
            end
        end
    end

    response_misr #(
        .SIG_W    (SIG_W),
        .SIG_POLY (SIG_POLY),
        .OUT_W    (OUT_W)
    ) u_misr (
        .clk (clk),
        .rst (rst),
        .clr (start_run),
        .en  (accept),
        .din (resp_in),
        .sig (signature)
    );

    assign vec_ready        = in_run;
    assign busy             = in_run;
    assign done             = (state_reg == DONE);
    assign pass             = done && (err_count_reg == '0);
    assign err_count        = err_count_reg;
    assign first_fail_valid = ff_valid_reg;
    assign first_fail_vec   = ff_vec_reg;

endmodule

// File: tb/tb_vector_response_checker.sv
// Self-checking bench: a transaction-level model of the checker is compared against the
// DUT on every falling edge, plus literal checks at the end of each directed scenario.
module tb_vector_response_checker;

    localparam logic [31:0] TB_EXPECT = 32'h9C3A_5E17;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        vec_valid = 1'b0;
    logic [3:0]  vec_in = '0;
    logic [1:0]  resp_in = '0;
    logic        vec_ready, busy, done, pass, first_fail_valid;
    logic [4:0]  err_count;
    logic [3:0]  first_fail_vec;
    logic [15:0] signature;

    vector_response_checker #(
        .IN_W     (4),
        .OUT_W    (2),
        .EXPECT   (TB_EXPECT),
        .SIG_W    (16),
        .SIG_POLY (16'h1021)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .vec_valid        (vec_valid),
        .vec_in           (vec_in),
        .resp_in          (resp_in),
        .vec_ready        (vec_ready),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .first_fail_valid (first_fail_valid),
        .first_fail_vec   (first_fail_vec),
        .signature        (signature)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: what the outputs must be after the most recent edge.
    bit          m_run   = 0;
    bit          m_done  = 0;
    int          m_err   = 0;
    int          m_cnt   = 0;
    bit          m_ffv   = 0;
    int          m_ffvec = 0;
    int          m_sig   = 0;
    int          exp_tbl [16];
    int          clean_sig;
    int          order [16];

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Signature step computed with integer arithmetic.
    function automatic int misr_model(input int s, input int r);
        int v;
        v = s * 2;
        if (v >= 65536) v = (v - 65536) ^ 'h1021;
        return v ^ r;
    endfunction

    task automatic model_reset();
        m_run = 0; m_done = 0; m_err = 0; m_cnt = 0;
        m_ffv = 0; m_ffvec = 0; m_sig = 0;
    endtask

    task automatic model_step(input bit st, input bit vv, input int v, input int r);
        int seq;
        if (!m_run && st) begin
            model_reset();
            m_run = 1;
        end else if (m_run && vv) begin
            seq = m_cnt % 16;
            if (v != seq || r != exp_tbl[seq]) begin
                if (!m_ffv) begin
                    m_ffv   = 1;
                    m_ffvec = v;
                end
                m_err++;
            end
            m_sig = misr_model(m_sig, r);
            m_cnt++;
            if (m_cnt == 16) begin
                m_run  = 0;
                m_done = 1;
            end
        end
    endtask

    // One clock cycle of stimulus; the model advances at the same edge as the DUT.
    task automatic cycle(input bit st, input bit vv, input int v, input int r);
        start     = st;
        vec_valid = vv;
        vec_in    = 4'(v);
        resp_in   = 2'(r);
        @(posedge clk);
        model_step(st, vv, v, r);
        #1;
        start     = 1'b0;
        vec_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_vec_ready"}, int'(vec_ready), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_err_count"}, int'(err_count), 0);
        chk({tag, "_ff_valid"}, int'(first_fail_valid), 0);
        chk({tag, "_ff_vec"}, int'(first_fail_vec), 0);
        chk({tag, "_signature"}, int'(signature), 0);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("cyc_vec_ready", int'(vec_ready), int'(m_run));
        chk("cyc_busy", int'(busy), int'(m_run));
        chk("cyc_done", int'(done), int'(m_done));
        chk("cyc_pass", int'(pass), int'(m_done && m_err == 0));
        chk("cyc_err_count", int'(err_count), m_err);
        chk("cyc_ff_valid", int'(first_fail_valid), int'(m_ffv));
        chk("cyc_ff_vec", int'(first_fail_vec), m_ffvec);
        chk("cyc_signature", int'(signature), m_sig);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1);
    end

    initial begin
        for (int v = 0; v < 16; v++) exp_tbl[v] = int'((TB_EXPECT >> (2 * v)) & 32'd3);

        // Power-on reset.
        #2;
        check_all_zero("por");
        @(negedge clk); #1 rst = 1'b0;
        cycle(0, 1, 0, 0);
        $display("reset released, idle pair ignored");

        // Clean run.
        cycle(1, 0, 0, 0);
        for (int v = 0; v < 16; v++) begin
            cycle(0, 1, v, exp_tbl[v]);
            if (v == 2) chk("sig_after_3", int'(signature), 'h000F);
        end
        cycle(0, 1, 0, 0);
        chk("clean_done", int'(done), 1);
        chk("clean_pass", int'(pass), 1);
        chk("clean_err", int'(err_count), 0);
        chk("clean_ffv", int'(first_fail_valid), 0);
        clean_sig = m_sig;
        $display("clean run: err=%0d sig=%h", err_count, signature);

        // Single fault at vector 5.
        cycle(1, 0, 0, 0);
        for (int v = 0; v < 16; v++)
            cycle(0, 1, v, (v == 5) ? (exp_tbl[v] ^ 3) : exp_tbl[v]);
        chk("fault_err", int'(err_count), 1);
        chk("fault_ffvec", int'(first_fail_vec), 5);
        chk("fault_ffv", int'(first_fail_valid), 1);
        chk("fault_pass", int'(pass), 0);
        chk("fault_sig_differs", int'(signature != 16'(clean_sig)), 1);
        $display("single fault run: err=%0d first=%0d sig=%h", err_count, first_fail_vec, signature);

        // Restart from DONE with a coincident valid pair (must not be accepted).
        cycle(1, 1, 0, exp_tbl[0]);
        chk("restart_err", int'(err_count), 0);
        chk("restart_ffv", int'(first_fail_valid), 0);
        chk("restart_ffvec", int'(first_fail_vec), 0);
        chk("restart_sig", int'(signature), 0);
        chk("restart_busy", int'(busy), 1);
        $display("restart from done: busy=%0d err=%0d sig=%h", busy, err_count, signature);

        // Sequence error 0,1,3,2,4..15 with a stray start mid-run.
        for (int i = 0; i < 16; i++) order[i] = i;
        order[2] = 3;
        order[3] = 2;
        for (int i = 0; i < 16; i++)
            cycle((i == 8), 1, order[i], exp_tbl[order[i]]);
        chk("seq_err", int'(err_count), 2);
        chk("seq_ffvec", int'(first_fail_vec), 3);
        chk("seq_done", int'(done), 1);
        $display("sequence error run: err=%0d first=%0d", err_count, first_fail_vec);

        // Gapped valid, every response wrong.
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 32; i++)
            cycle(0, (i % 2 == 0), i / 2, exp_tbl[i / 2] ^ 1);
        chk("gap_err", int'(err_count), 16);
        chk("gap_done", int'(done), 1);
        chk("gap_ffvec", int'(first_fail_vec), 0);
        $display("gapped run: err=%0d done=%0d", err_count, done);

        // Reset after 7 accepts.
        cycle(1, 0, 0, 0);
        for (int v = 0; v < 7; v++) cycle(0, 1, v, exp_tbl[v] ^ 2);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all_zero("midrst");
        @(negedge clk); #1 rst = 1'b0;
        $display("mid-run reset: all outputs cleared");

        // Full correct run after reset.
        cycle(1, 0, 0, 0);
        for (int v = 0; v < 16; v++) cycle(0, 1, v, exp_tbl[v]);
        chk("post_rst_pass", int'(pass), 1);
        chk("post_rst_sig", int'(signature), clean_sig);
        $display("post-reset clean run: pass=%0d sig=%h", pass, signature);

        cycle(0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
